// File: rtl/board_pkg.sv
// Shared constants, FSM encoding and helpers for the battleship board memory placer.
// Cell-status codes are plain integers; each user sizes them to its own STATUS_W.
package board_pkg;

    localparam int unsigned COORD_W = 4;   // external cell coordinate width
    localparam int unsigned WALK_W  = 5;   // walk arithmetic width, x+len-1 never wraps
    localparam int unsigned LEN_W   = 4;   // ship length / walk index width
    localparam int unsigned LIN_W   = 2 * WALK_W;

    localparam int unsigned CELL_FREE = 0;
    localparam int unsigned CELL_SHIP = 1;
    localparam int unsigned CELL_HIT  = 2;
    localparam int unsigned CELL_MISS = 3;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } place_state_e;

    function automatic int unsigned addr_width(input int unsigned cells);
        return (cells > 1) ? $clog2(cells) : 1;
    endfunction

    function automatic logic ship_len_ok(input logic [LEN_W-1:0] len,
                                         input int unsigned max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/cell_walker.sv
// Maps (origin, direction, index) to a linear cell address plus an in-bounds flag.
// Out-of-bounds cells report address 0 so callers never index past the array.
module cell_walker
    import board_pkg::*;
#(
    parameter int unsigned GRID_W = 10,
    parameter int unsigned GRID_H = 10,
    parameter int unsigned ADDR_W = 7
) (
    input  logic [COORD_W-1:0] origin_x,
    input  logic [COORD_W-1:0] origin_y,
    input  logic               direction,
    input  logic [LEN_W-1:0]   index,
    output logic [ADDR_W-1:0]  addr,
    output logic               in_bounds
);

    logic [WALK_W-1:0] cell_x;
    logic [WALK_W-1:0] cell_y;
    logic [LIN_W-1:0]  linear;

    always_comb begin
        cell_x    = WALK_W'(origin_x) + (direction ? '0 : WALK_W'(index));
        cell_y    = WALK_W'(origin_y) + (direction ? WALK_W'(index) : '0);
        in_bounds = (cell_x < WALK_W'(GRID_W)) && (cell_y < WALK_W'(GRID_H));
        linear    = LIN_W'(cell_y) * LIN_W'(GRID_W) + LIN_W'(cell_x);
        addr      = in_bounds ? ADDR_W'(linear) : '0;
    end

endmodule

// File: rtl/board_mem_placer.sv
// Board status memory with two registered read ports, direct cell writes,
// and a checked multi-cell ship placement walker plus a full-board clear.
module board_mem_placer
    import board_pkg::*;
#(
    parameter int unsigned GRID_W   = 10,
    parameter int unsigned GRID_H   = 10,
    parameter int unsigned STATUS_W = 5,
    parameter int unsigned MAX_SHIP = 5
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [COORD_W-1:0]  mouse_cell_x,
    input  logic [COORD_W-1:0]  mouse_cell_y,
    input  logic [COORD_W-1:0]  pointer_cell_x,
    input  logic [COORD_W-1:0]  pointer_cell_y,
    input  logic                we,
    input  logic [STATUS_W-1:0] new_value,
    input  logic                place_req,
    input  logic [LEN_W-1:0]    ship_length,
    input  logic                direction,
    input  logic [STATUS_W-1:0] place_value,
    input  logic                clear_req,
    output logic                busy,
    output logic                ship_placed,
    output logic                place_err,
    output logic [STATUS_W-1:0] status,
    output logic [STATUS_W-1:0] status_pointed_cell
);

    localparam int unsigned CELLS  = GRID_W * GRID_H;
    localparam int unsigned ADDR_W = addr_width(CELLS);
    localparam logic [STATUS_W-1:0] FREE      = STATUS_W'(CELL_FREE);
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(CELLS - 1);

    place_state_e        state;
    logic [ADDR_W-1:0]   clr_idx;
    logic [LEN_W-1:0]    walk_idx;
    logic [COORD_W-1:0]  org_x;
    logic [COORD_W-1:0]  org_y;
    logic [LEN_W-1:0]    len_q;
    logic                dir_q;
    logic [STATUS_W-1:0] value_q;

    logic [STATUS_W-1:0] mem [CELLS];

    logic [ADDR_W-1:0]   walk_addr;
    logic                walk_in;
    logic [ADDR_W-1:0]   mouse_addr;
    logic                mouse_in;
    logic [ADDR_W-1:0]   pointer_addr;
    logic                pointer_in;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [STATUS_W-1:0] wr_data;
    logic                check_fail;
    logic                walk_last;

    // Shared by CHECK and WRITE so both phases visit exactly the same cells.
    cell_walker #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W)) u_walk (
        .origin_x  (org_x),
        .origin_y  (org_y),
        .direction (dir_q),
        .index     (walk_idx),
        .addr      (walk_addr),
        .in_bounds (walk_in)
    );

    cell_walker #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W)) u_mouse (
        .origin_x  (mouse_cell_x),
        .origin_y  (mouse_cell_y),
        .direction (1'b0),
        .index     ('0),
        .addr      (mouse_addr),
        .in_bounds (mouse_in)
    );

    cell_walker #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W)) u_pointer (
        .origin_x  (pointer_cell_x),
        .origin_y  (pointer_cell_y),
        .direction (1'b0),
        .index     ('0),
        .addr      (pointer_addr),
        .in_bounds (pointer_in)
    );

    assign busy       = (state != ST_IDLE);
    assign walk_last  = (walk_idx == len_q - LEN_W'(1));
    assign check_fail = !ship_len_ok(len_q, MAX_SHIP) || !walk_in || (mem[walk_addr] != FREE);

    // Single write port: CLEAR, WRITE and idle direct writes never overlap.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        wr_en   = 1'b0;
        wr_addr = walk_addr;
        wr_data = value_q;
        if (!rst) begin
            case (state)
                ST_CLEAR: begin
                    wr_en   = 1'b1;
                    wr_addr = clr_idx;
                    wr_data = FREE;
                end
                ST_IDLE: begin
                    if (we && !place_req && !clear_req && mouse_in) begin
                        wr_en   = 1'b1;
                        wr_addr = mouse_addr;
                        wr_data = new_value;
                    end
                end
                ST_WRITE: wr_en = walk_in;
                default: ;
            endcase
        end
    end

    // NOTE: the cell array has no reset; the CLEAR walk that reset starts wipes it.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads sample the array before this edge's write lands.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            status              <= FREE;
            status_pointed_cell <= FREE;
        end else begin
            status              <= mouse_in   ? mem[mouse_addr]   : FREE;
            status_pointed_cell <= pointer_in ? mem[pointer_addr] : FREE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= ST_CLEAR;
            clr_idx     <= '0;
            walk_idx    <= '0;
            org_x       <= '0;
            org_y       <= '0;
            len_q       <= '0;
            dir_q       <= 1'b0;
            value_q     <= '0;
            ship_placed <= 1'b0;
            place_err   <= 1'b0;
        end else begin
            ship_placed <= 1'b0;
            place_err   <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_idx == LAST_ADDR) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_idx <= clr_idx + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        clr_idx <= '0;
                        state   <= ST_CLEAR;
                    end else if (place_req) begin
                        org_x    <= mouse_cell_x;
                        org_y    <= mouse_cell_y;
                        len_q    <= ship_length;
                        dir_q    <= direction;
                        value_q  <= place_value;
                        walk_idx <= '0;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (check_fail) begin
                        state <= ST_ERR;
                    end else if (walk_last) begin
                        walk_idx <= '0;
                        state    <= ST_WRITE;
                    end else begin
                        walk_idx <= walk_idx + LEN_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (walk_last) begin
                        state <= ST_DONE;
                    end else begin
                        walk_idx <= walk_idx + LEN_W'(1);
                    end
                end
                ST_DONE: begin
                    ship_placed <= 1'b1;
                    state       <= ST_IDLE;
                end
                ST_ERR: begin
                    place_err <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_board_mem_placer.sv
// Directed bench for board_mem_placer: reset clear, direct writes, placement,
// overlap/boundary/length errors, priorities, busy-ignore and mid-operation reset.
module tb_board_mem_placer;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mouse_cell_x = '0;
    logic [3:0] mouse_cell_y = '0;
    logic [3:0] pointer_cell_x = '0;
    logic [3:0] pointer_cell_y = '0;
    logic       we = 1'b0;
    logic [4:0] new_value = '0;
    logic       place_req = 1'b0;
    logic [3:0] ship_length = '0;
    logic       direction = 1'b0;
    logic [4:0] place_value = '0;
    logic       clear_req = 1'b0;
    logic       busy;
    logic       ship_placed;
    logic       place_err;
    logic [4:0] status;
    logic [4:0] status_pointed_cell;

    int vectors = 0;
    int miscompares = 0;

    board_mem_placer dut (
        .clk_in              (clk_in),
        .rst                 (rst),
        .mouse_cell_x        (mouse_cell_x),
        .mouse_cell_y        (mouse_cell_y),
        .pointer_cell_x      (pointer_cell_x),
        .pointer_cell_y      (pointer_cell_y),
        .we                  (we),
        .new_value           (new_value),
        .place_req           (place_req),
        .ship_length         (ship_length),
        .direction           (direction),
        .place_value         (place_value),
        .clear_req           (clear_req),
        .busy                (busy),
        .ship_placed         (ship_placed),
        .place_err           (place_err),
        .status              (status),
        .status_pointed_cell (status_pointed_cell)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic read2(input int mx, input int my, input int px, input int py);
        mouse_cell_x   = 4'(mx);
        mouse_cell_y   = 4'(my);
        pointer_cell_x = 4'(px);
        pointer_cell_y = 4'(py);
        @(negedge clk_in);
    endtask

    task automatic poke(input int x, input int y, input int val);
        mouse_cell_x = 4'(x);
        mouse_cell_y = 4'(y);
        new_value    = 5'(val);
        we           = 1'b1;
        @(negedge clk_in);
        we = 1'b0;
    endtask

    task automatic place(input int x, input int y, input int len, input int dir, input int val);
        mouse_cell_x = 4'(x);
        mouse_cell_y = 4'(y);
        ship_length  = 4'(len);
        direction    = dir[0];
        place_value  = 5'(val);
        place_req    = 1'b1;
        @(negedge clk_in);
        place_req = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (ship_placed !== 1'b1 && place_err !== 1'b1 && lat < 100) begin
            @(negedge clk_in);
            lat++;
        end
    endtask

    task automatic wait_idle(output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk_in);
            n++;
            if (ship_placed === 1'b1) pulses++;
        end
    endtask

    task automatic check_board_clean(input string tag);
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                read2(x, y, 9 - x, 9 - y);
                check(tag, {status, status_pointed_cell}, 10'd0);
            end
        end
    endtask

    initial begin
        int lat;
        int n;
        int pulses;

        // Reset and initial clear
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        check("rst_busy", busy, 1);
        check("rst_placed", ship_placed, 0);
        check("rst_err", place_err, 0);
        check("rst_status", status, 0);
        check("rst_pointed", status_pointed_cell, 0);
        wait_idle(n, pulses);
        check("rst_clear_cycles", n, 100);
        check_board_clean("rst_board_clean");

        // Direct writes, out-of-range write and read
        poke(0, 1, 7);
        poke(15, 0, 5);
        read2(0, 1, 5, 1);
        check("we_write", status, 7);
        check("we_oob_ignored", status_pointed_cell, 0);
        read2(10, 0, 0, 1);
        check("oob_read_free", status, 0);
        check("pointer_read", status_pointed_cell, 7);

        // Horizontal placement
        place(2, 3, 4, 0, 1);
        wait_result(lat);
        check("h_placed", ship_placed, 1);
        check("h_no_err", place_err, 0);
        check("h_latency", lat, 9);
        @(negedge clk_in);
        check("h_pulse_width", ship_placed, 0);
        check("h_idle", busy, 0);
        read2(2, 3, 3, 3);
        check("h_cells_23_33", {status, status_pointed_cell}, {5'd1, 5'd1});
        read2(4, 3, 5, 3);
        check("h_cells_43_53", {status, status_pointed_cell}, {5'd1, 5'd1});
        read2(6, 3, 1, 3);
        check("h_cells_63_13", {status, status_pointed_cell}, 10'd0);

        // Overlap error
        place(4, 1, 3, 1, 2);
        wait_result(lat);
        check("ovl_err", place_err, 1);
        check("ovl_no_placed", ship_placed, 0);
        read2(4, 1, 4, 3);
        check("ovl_41_43", {status, status_pointed_cell}, {5'd0, 5'd1});
        read2(4, 2, 4, 2);
        check("ovl_42", status, 0);

        // Right boundary: reaching column 10 errors, column 9 fits without wrap
        place(7, 0, 4, 0, 2);
        wait_result(lat);
        check("bnd_err", place_err, 1);
        @(negedge clk_in);
        check("bnd_err_pulse_width", place_err, 0);
        read2(7, 0, 9, 0);
        check("bnd_err_untouched", {status, status_pointed_cell}, 10'd0);
        place(6, 0, 4, 0, 2);
        wait_result(lat);
        check("bnd_placed", ship_placed, 1);
        check("bnd_latency", lat, 9);
        read2(6, 0, 9, 0);
        check("bnd_cells", {status, status_pointed_cell}, {5'd2, 5'd2});
        read2(0, 1, 5, 0);
        check("bnd_no_wrap", {status, status_pointed_cell}, {5'd7, 5'd0});

        // Length 0 and length above the maximum
        place(0, 9, 0, 0, 1);
        wait_result(lat);
        check("len0_err", place_err, 1);
        place(0, 9, 6, 0, 1);
        wait_result(lat);
        check("len6_err", place_err, 1);
        read2(0, 9, 5, 9);
        check("len_err_untouched", {status, status_pointed_cell}, 10'd0);

        // place_req beats we on the same edge
        mouse_cell_x = 4'd8;
        mouse_cell_y = 4'd8;
        ship_length  = 4'd1;
        direction    = 1'b0;
        place_value  = 5'd3;
        new_value    = 5'd6;
        we           = 1'b1;
        place_req    = 1'b1;
        @(negedge clk_in);
        we        = 1'b0;
        place_req = 1'b0;
        wait_result(lat);
        check("prio_placed", ship_placed, 1);
        check("prio_latency", lat, 3);
        read2(8, 8, 8, 8);
        check("prio_cell", status, 3);

        // we and clear_req during WRITE are ignored
        place(0, 5, 3, 0, 4);
        repeat (4) @(negedge clk_in);
        check("busy_in_write", busy, 1);
        mouse_cell_x = 4'd0;
        mouse_cell_y = 4'd0;
        new_value    = 5'd3;
        we           = 1'b1;
        clear_req    = 1'b1;
        @(negedge clk_in);
        we        = 1'b0;
        clear_req = 1'b0;
        wait_result(lat);
        check("bi_placed", ship_placed, 1);
        check("bi_latency_rest", lat, 2);
        read2(0, 0, 2, 5);
        check("bi_cells", {status, status_pointed_cell}, {5'd0, 5'd4});
        read2(0, 5, 2, 3);
        check("bi_not_cleared", {status, status_pointed_cell}, {5'd4, 5'd1});

        // clear_req beats place_req and we
        mouse_cell_x = 4'd1;
        mouse_cell_y = 4'd1;
        ship_length  = 4'd1;
        place_value  = 5'd9;
        new_value    = 5'd2;
        we           = 1'b1;
        place_req    = 1'b1;
        clear_req    = 1'b1;
        @(negedge clk_in);
        we        = 1'b0;
        place_req = 1'b0;
        clear_req = 1'b0;
        wait_idle(n, pulses);
        check("clr_cycles", n, 100);
        check("clr_no_placed", pulses, 0);
        read2(3, 3, 1, 1);
        check("clr_cells_33_11", {status, status_pointed_cell}, 10'd0);
        read2(6, 0, 8, 8);
        check("clr_cells_60_88", {status, status_pointed_cell}, 10'd0);

        // Reset in the middle of WRITE of a length-5 ship
        place(0, 8, 5, 0, 6);
        repeat (7) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        check("mid_rst_busy", busy, 1);
        check("mid_rst_placed", ship_placed, 0);
        wait_idle(n, pulses);
        check("mid_rst_clear_cycles", n, 100);
        check("mid_rst_no_pulse", pulses, 0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk_in);
            if (ship_placed === 1'b1) pulses++;
        end
        check("mid_rst_no_late_pulse", pulses, 0);
        check_board_clean("mid_rst_board_clean");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/board_mem_placer.md
BOARD_MEM_PLACER -- requirements
Module: board_mem_placer

Interface
REQ-001 SHALL have parameter GRID_W, default 10, board columns (1..16).
REQ-002 SHALL have parameter GRID_H, default 10, board rows (1..16).
REQ-003 SHALL have parameter STATUS_W, default 5, cell status width.
REQ-004 SHALL have parameter MAX_SHIP, default 5, longest ship length accepted.
REQ-005 SHALL have port clk_in  in  1  the only clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports mouse_cell_x, mouse_cell_y  in  4 each  placement origin / direct-write cell.
REQ-008 SHALL have ports pointer_cell_x, pointer_cell_y  in  4 each  second read cell.
REQ-009 SHALL have ports we  in  1, and new_value  in  STATUS_W  direct single-cell write.
REQ-010 SHALL have ports place_req  in  1, ship_length  in  4, direction  in  1 (0 = +x, 1 = +y), and place_value  in  STATUS_W  ship placement request.
REQ-011 SHALL have port clear_req  in  1  wipe the whole board to CELL_FREE.
REQ-012 SHALL have ports busy  out  1, ship_placed  out  1 (pulse), and place_err  out  1 (pulse).
REQ-013 SHALL have ports status  out  STATUS_W (mouse cell) and status_pointed_cell  out  STATUS_W (pointer cell).

Function
REQ-014 SHALL store GRID_W*GRID_H cells of STATUS_W bits, addressed as y*GRID_W+x.
REQ-015 SHALL register both read ports with 1-cycle latency; an out-of-range coordinate SHALL read CELL_FREE.
REQ-016 SHALL use the FSM states CLEAR, IDLE, CHECK, WRITE, DONE, ERR.
REQ-017 In IDLE, we=1 SHALL write new_value to the in-range mouse cell on that edge; an out-of-range write SHALL be ignored.
REQ-018 In IDLE, place_req=1 SHALL latch the origin, ship_length, direction and place_value, then enter CHECK; place_req SHALL take priority over we on the same edge.
REQ-019 In IDLE, clear_req=1 SHALL enter CLEAR; clear_req SHALL take priority over place_req and we.
REQ-020 CHECK SHALL visit one cell per cycle, covering ship_length cells.
REQ-021 CHECK SHALL go to ERR if any visited cell is out of bounds or not CELL_FREE.
REQ-022 CHECK SHALL go to ERR immediately if ship_length is 0 or greater than MAX_SHIP.
REQ-023 If all visited cells are valid and free, CHECK SHALL go to WRITE.
REQ-024 WRITE SHALL write place_value to one cell per cycle for ship_length cycles, then enter DONE.
REQ-025 DONE SHALL pulse ship_placed for 1 cycle and return to IDLE; ERR SHALL pulse place_err for 1 cycle and return to IDLE without modifying memory.
REQ-026 Total placement latency SHALL be 2*ship_length+1 cycles from the accepting edge to the ship_placed pulse.
REQ-027 CLEAR SHALL write CELL_FREE to one cell per cycle, addresses 0..GRID_W*GRID_H-1, then enter IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Requests and we received while busy SHALL be ignored, not queued.
REQ-030 Cell coordinate arithmetic SHALL be 5 bits wide, so x+len-1 cannot wrap; a ship reaching past the last column or row SHALL produce ERR, never wrap to the next row.
REQ-031 Read ports SHALL remain functional in all states; they show contents before the same-cycle write.

Reset
REQ-032 rst=1 SHALL force state CLEAR with the cell index at 0, set ship_placed=0, place_err=0 and status=status_pointed_cell=CELL_FREE.
REQ-033 busy SHALL be 1 from the first cycle after rst is sampled until CLEAR finishes.
REQ-034 rst asserted mid-CHECK, mid-WRITE or mid-CLEAR SHALL abort the operation and restart CLEAR; a partial ship SHALL be erased.

Structure
REQ-035 CELL_FREE (0), the FSM state encoding and the cell-status code constants SHALL reside in a shared package, board_pkg.
REQ-036 The cell walker (origin, direction, index -> address plus in_bounds) SHALL be one sub-module, cell_walker, shared by CHECK and WRITE.

Verification
REQ-037 Reset: rst for 1 cycle, then wait 100 cycles -> busy falls after 100 cycles of CLEAR; every cell reads 0.
REQ-038 Horizontal placement: origin (2,3), length 4, dir 0, value 1 -> ship_placed 9 cycles later; cells (2..5,3)=1 and (6,3)=0.
REQ-039 Overlap: then origin (4,1), length 3, dir 1 -> place_err pulse; cell (4,1)=0 and cell (4,3) is still 1.
REQ-040 Boundary: origin (7,0), length 4, dir 0 on a 10x10 board -> place_err; origin (6,0), length 4 -> ship_placed.
REQ-041 Busy-ignore: we=1 at (0,0) with value 3 during WRITE -> cell (0,0) remains 0.
REQ-042 Mid-op reset: rst during WRITE of a length-5 ship -> all cells are 0 after CLEAR, and no ship_placed pulse occurs.
